// File: rtl/contador_pkg.sv
// contador_pkg: shared width default and direction constants for the contador_ud counter.
package contador_pkg;
    localparam int CONTADOR_DEFAULT_WIDTH = 4;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/contador_ud_if.sv
// contador_ud_if: step request/direction in, count and status flags out.
interface contador_ud_if import contador_pkg::*; #(
    parameter int WIDTH = CONTADOR_DEFAULT_WIDTH
);
    logic nxt;
    logic dir;
    logic empty;
    logic full;
    logic [WIDTH-1:0] cuenta;
    modport master (output nxt, dir, input empty, full, cuenta);
    modport slave (input nxt, dir, output empty, full, cuenta);
endinterface

// File: rtl/contador_edge.sv
// contador_edge: rising-edge detector; the history register is unreset so a level held through reset yields no pulse.
module contador_edge (
    input  logic clk,
    input  logic d,
    output logic pulse
);
    logic d_q;
    always_ff @(posedge clk) d_q <= d;
    assign pulse = d & ~d_q;
endmodule

// File: rtl/contador_ud.sv
// contador_ud: saturating up/down counter with empty/full flags.
// Define CONTADOR_NXT_EDGE_EN to step once per nxt rising edge instead of once per nxt-high cycle.
module contador_ud import contador_pkg::*; #(
    parameter int WIDTH = CONTADOR_DEFAULT_WIDTH
) (
    input logic clk,
    input logic rst,
    contador_ud_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX = '1;
    logic step;
    logic [WIDTH-1:0] cuenta_q, cuenta_d;
`ifdef CONTADOR_NXT_EDGE_EN
    contador_edge u_edge (.clk(clk), .d(bus.nxt), .pulse(step));
`else
    assign step = bus.nxt;
`endif
    // Bounds are checked before the update so the count never wraps.
    always_comb begin
        cuenta_d = cuenta_q;
        if (step)
            cuenta_d = (bus.dir == DIR_UP) ? ((cuenta_q != MAX) ? cuenta_q + WIDTH'(1) : cuenta_q)
                                           : ((cuenta_q != '0) ? cuenta_q - WIDTH'(1) : cuenta_q);
    end
    always_ff @(posedge clk) begin
        if (rst) cuenta_q <= '0;
        else     cuenta_q <= cuenta_d;
    end
    assign bus.cuenta = cuenta_q;
    assign bus.empty = (cuenta_q == '0);
    assign bus.full = (cuenta_q == MAX);
endmodule

// File: tb/tb_contador_ud.sv
// tb_contador_ud: directed vector table, hand sequences and a randomized model check for contador_ud (WIDTH=2).
module tb_contador_ud;
    localparam int W = 2;
    localparam int MAXC = (1 << W) - 1;
    typedef struct {
        logic r;
        logic n;
        logic d;
        int c;
    } vec_t;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    contador_ud_if #(.WIDTH(W)) bus ();
    contador_ud #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int c);
        chk({name, ".cuenta"}, int'(bus.cuenta), c);
        chk({name, ".empty"}, int'(bus.empty), int'(c == 0));
        chk({name, ".full"}, int'(bus.full), int'(c == MAXC));
    endtask

    task automatic cyc(input logic r, input logic n, input logic d);
        @(negedge clk);
        rst = r;
        bus.nxt = n;
        bus.dir = d;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic r, input logic n, input logic d, input int c);
        vec_t v;
        v.r = r; v.n = n; v.d = d; v.c = c;
        tbl.push_back(v);
    endfunction

    initial begin
        int up_exp[6] = '{1, 2, 3, 3, 3, 3};
        int dn_exp[5] = '{2, 1, 0, 0, 0};
        int cnt, prev, hold_exp;
        logic r, n, d, step;
        rst = 1'b1;
        bus.nxt = 1'b0;
        bus.dir = 1'b0;
        add(1, 0, 1, 0);
        foreach (up_exp[i]) begin add(0, 1, 1, up_exp[i]); add(0, 0, 1, up_exp[i]); end
        foreach (dn_exp[i]) begin add(0, 1, 0, dn_exp[i]); add(0, 0, 0, dn_exp[i]); end
        add(0, 1, 1, 1); add(0, 0, 1, 1); add(0, 1, 1, 2); add(0, 0, 1, 2);
        add(1, 1, 1, 0); add(0, 0, 1, 0);
        add(0, 1, 1, 1); add(0, 0, 1, 1);
        for (int i = 0; i < 5; i++) add(0, 0, logic'(i % 2), 1);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].r, tbl[i].n, tbl[i].d);
            chk_all($sformatf("vec%0d", i), tbl[i].c);
        end
        // nxt held high for four cycles from zero
        cyc(1, 0, 1);
        chk_all("hold_rst", 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1);
`ifdef CONTADOR_NXT_EDGE_EN
        hold_exp = 1;
`else
        hold_exp = 3;
`endif
        chk_all("hold_high", hold_exp);
        // nxt held high through reset release never steps in edge mode
        cyc(1, 1, 1);
        cyc(0, 1, 1);
`ifdef CONTADOR_NXT_EDGE_EN
        chk_all("held_thru_rst", 0);
`else
        chk_all("held_thru_rst", 1);
`endif
        cyc(1, 0, 0);
        cnt = 0;
        prev = 0;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 24) == 0);
            n = $urandom_range(0, 1);
            d = $urandom_range(0, 1);
`ifdef CONTADOR_NXT_EDGE_EN
            step = n && (prev == 0);
`else
            step = n;
`endif
            prev = int'(n);
            if (r) cnt = 0;
            else if (step) cnt = d ? ((cnt < MAXC) ? cnt + 1 : cnt) : ((cnt > 0) ? cnt - 1 : cnt);
            cyc(r, n, d);
            chk_all($sformatf("rand%0d", i), cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/contador_ud.md
# contador_ud

Synchronous up/down counter with saturation and full/empty status flags. A step request (`nxt`) moves the count one position in the direction selected by `dir`. The count holds at 0 and at its maximum value. The block is a small utility used as an occupancy/position tracker by control logic that needs direct zero and maximum indications.

## Interface
- `WIDTH`, default 4: counter width in bits, must be ≥ 1; the maximum count is 2^WIDTH−1.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset: one clock, synchronous, active-high.
- `nxt`  in  1  step request.
- `dir`  in  1  direction: 1 = up, 0 = down; sampled with `nxt`.
- `empty`  out  1  high when `cuenta` == 0.
- `full`  out  1  high when `cuenta` == 2^WIDTH−1.
- `cuenta`  out  WIDTH  current count, registered.

## Operation
- Internal step strobe `step` is derived from `nxt`; see Configuration.
- `step` && `dir` == 1 && `cuenta` < max: `cuenta` increments by 1.
- `step` && `dir` == 0 && `cuenta` > 0: `cuenta` decrements by 1.
- At max, an up step leaves `cuenta` unchanged; there is no wrap to 0.
- At 0, a down step leaves `cuenta` unchanged; there is no wrap to max.
- No `step`: `cuenta` holds.
- `empty` and `full` are combinational decodes of the registered `cuenta`, with no extra register stage.
- WIDTH = 1: max is 1; `empty` and `full` are mutually exclusive and always exactly one of them is high.
- Arithmetic is unsigned, WIDTH bits.
- Saturation is detected by comparing against the bounds before the update, never by overflow.

## Timing
- Reset values: `cuenta` = 0, `empty` = 1, `full` = 0.
- `rst` has priority over `step`: a step in the same cycle as `rst` is discarded.
- Latency: a step qualified in cycle n is visible on `cuenta`, `empty` and `full` after the rising edge ending cycle n (1 cycle).
- `dir` only matters in cycles where `step` is high; changing `dir` has no effect otherwise.
- Reset mid-operation returns the count to 0 on the next edge; counting resumes in the first cycle with `rst` low.

## Configuration
- Macro `CONTADOR_NXT_EDGE_EN`.
- Defined: `step` = `nxt` && !`nxt_q`, where `nxt_q` is `nxt` registered every cycle, including during reset.
  - Exactly one step per `nxt` pulse, regardless of pulse length.
  - A `nxt` held high through reset release produces no step.
- Undefined: `step` = `nxt`; every clock cycle with `nxt` high is one step. No `nxt_q` register exists.

## Structure
- Shared package `contador_pkg` contains:
  - `CONTADOR_DEFAULT_WIDTH` = 4.
  - Direction constants `DIR_UP` = 1'b1 and `DIR_DOWN` = 1'b0.
- One sub-module, `contador_edge`: rising-edge detector with ports `clk`, `d`, `pulse`. It is instantiated only under `CONTADOR_NXT_EDGE_EN`.
- The counter register, saturation logic and flag decode live in the top module.

## Test plan
All scenarios use WIDTH = 2 and apply `nxt` as 1-cycle pulses, so they pass in both configurations.
- Reset: pulse `rst` for 1 cycle -> `cuenta` = 0, `empty` = 1, `full` = 0.
- Count up: `dir` = 1, 6 `nxt` pulses -> `cuenta` reads 1, 2, 3, 3, 3, 3; `full` = 1 from the third pulse onward.
- Count down: following that, `dir` = 0, 5 pulses -> `cuenta` reads 2, 1, 0, 0, 0; `empty` = 1 from the third pulse onward.
- Reset priority: with `cuenta` = 2, assert `rst` and an up `nxt` in the same cycle -> `cuenta` = 0 next cycle, no increment.
- Hold and direction change: `nxt` low while `dir` toggles for 5 cycles -> `cuenta` unchanged.
- Configuration-dependent, `nxt` held high for 4 cycles with `dir` = 1 from 0:
  - With `CONTADOR_NXT_EDGE_EN` -> `cuenta` = 1.
  - Without the macro -> `cuenta` = 3, saturated, `full` = 1.
